bias_relu_sequencer: RTL and testbench

BIAS_RELU_SEQUENCER -- requirements
Module: bias_relu_sequencer

---
 rtl/bias_relu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_bias_relu_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_relu_sequencer.sv
// bias_relu_sequencer
//   Adds a per-channel bias to a stream of convolution results and applies
//   ReLU. One feature map is FILTERS channels of OUTPUT_SIZE**2 pixels, with
//   words arriving channel-major. Biases are captured at start and held for
//   the whole map. The output is a one-deep registered stage with a
//   valid/ready handshake.
//
//   Optional build macro: BIAS_RELU_SAT_EN
//     defined   -> the bias add saturates to the signed range
//     undefined -> the bias add wraps modulo 2**BIT_SIZE
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   start      single-cycle request to process one map (honoured in IDLE only)
//   biases     FILTERS packed biases, bias k at [k*BIT_SIZE +: BIT_SIZE]
//   in_data    input word
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle
//   out_data   biased, rectified word
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data
//   out_last   out_data is the final word of the map
//   busy       FSM is not in IDLE
//   done       one-cycle pulse when the map completes
module bias_relu_sequencer #(
    parameter int FILTERS     = 1,
    parameter int OUTPUT_SIZE = 3,
    parameter int BIT_SIZE    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [FILTERS*BIT_SIZE-1:0] biases,
    input  logic [BIT_SIZE-1:0]         in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [BIT_SIZE-1:0]         out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int PIX   = OUTPUT_SIZE * OUTPUT_SIZE;
    localparam int PIX_W = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int F_W   = (FILTERS > 1) ? $clog2(FILTERS) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX - 1);
    localparam logic [F_W-1:0]   F_LAST   = F_W'(FILTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [FILTERS*BIT_SIZE-1:0] r_biases;
    logic [PIX_W-1:0]            r_pix;
    logic [F_W-1:0]              r_f;
    logic [BIT_SIZE-1:0]         r_out_data;
    logic                        r_out_valid;
    logic                        r_out_last;

    logic                        w_in_ready;
    logic                        w_beat;
    logic                        w_out_take;
    logic                        w_last_beat;
    logic [BIT_SIZE-1:0]         w_bias;
    logic [BIT_SIZE-1:0]         w_sum;
    logic [BIT_SIZE-1:0]         w_relu;

    always_comb begin
        // Input is accepted only when the output stage is empty or draining
        // this same cycle, so the one-deep stage never overflows.
        w_in_ready  = (r_state == S_RUN) && (!r_out_valid || out_ready);
        w_beat      = in_valid && w_in_ready;
        w_out_take  = r_out_valid && out_ready;
        w_last_beat = (r_f == F_LAST) && (r_pix == PIX_LAST);
    end

    // Explicit compare-mux keeps the select in range for any FILTERS value.
    always_comb begin
        w_bias = '0;
        for (int unsigned k = 0; k < FILTERS; k++) begin
            if (r_f == F_W'(k)) begin
                w_bias = r_biases[k*BIT_SIZE +: BIT_SIZE];
            end
        end
    end

`ifdef BIAS_RELU_SAT_EN
    logic [BIT_SIZE:0] w_sum_ext;

    always_comb begin
        w_sum_ext = {in_data[BIT_SIZE-1], in_data} + {w_bias[BIT_SIZE-1], w_bias};
        // Top two bits differ only on signed overflow; the top bit gives its direction.
        if (w_sum_ext[BIT_SIZE] != w_sum_ext[BIT_SIZE-1]) begin
            w_sum = w_sum_ext[BIT_SIZE] ? {1'b1, {(BIT_SIZE-1){1'b0}}}
                                        : {1'b0, {(BIT_SIZE-1){1'b1}}};
        end else begin
            w_sum = w_sum_ext[BIT_SIZE-1:0];
        end
    end
`else
    always_comb begin
        w_sum = in_data + w_bias;
    end
`endif

    always_comb begin
        w_relu = w_sum[BIT_SIZE-1] ? '0 : w_sum;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start)                   w_state_next = S_RUN;
            S_RUN:   if (w_beat && w_last_beat)   w_state_next = S_DRAIN;
            S_DRAIN: if (w_out_take)              w_state_next = S_DONE;
            S_DONE:                               w_state_next = S_IDLE;
            default:                              w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = w_in_ready;
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        out_data  = r_out_data;
        out_valid = r_out_valid;
        out_last  = r_out_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_biases    <= '0;
            r_pix       <= '0;
            r_f         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && start) begin
                r_biases <= biases;
                r_pix    <= '0;
                r_f      <= '0;
            end
            if (w_beat) begin
                r_out_data  <= w_relu;
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_beat;
                if (r_pix == PIX_LAST) begin
                    r_pix <= '0;
                    r_f   <= r_f + 1'b1;
                end else begin
                    r_pix <= r_pix + 1'b1;
                end
            end else if (w_out_take) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bias_relu_sequencer.sv
module tb_bias_relu_sequencer;

    localparam int FILTERS     = 2;
    localparam int OUTPUT_SIZE = 2;
    localparam int BIT_SIZE    = 16;
    localparam int PIX         = OUTPUT_SIZE * OUTPUT_SIZE;
    localparam int NW          = FILTERS * PIX;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] biases;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    bias_relu_sequencer #(
        .FILTERS    (FILTERS),
        .OUTPUT_SIZE(OUTPUT_SIZE),
        .BIT_SIZE   (BIT_SIZE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .biases   (biases),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Map description and knobs for run_map.
    logic [31:0] m_bias;
    logic [15:0] m_in  [NW];
    logic [15:0] m_exp [NW];
    int          k_piv;
    int          k_por;
    bit          k_stall;
    bit          k_start_mid;
    bit          k_abort;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed add of word and its channel bias, then clamp negatives to 0.
    function automatic logic [15:0] ref_word(input logic [15:0] x, input logic [15:0] b);
        int          s;
        logic [15:0] w;
        s = int'($signed(x)) + int'($signed(b));
`ifdef BIAS_RELU_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        w = (s < 0) ? 16'h0000 : 16'(s);
`else
        w = 16'(s);
        if (w[15]) w = 16'h0000;
`endif
        return w;
    endfunction

    task automatic run_map(input string name);
        int          in_idx;
        int          out_idx;
        int          done_cnt;
        int          done_cyc;
        int          last_in_cyc;
        int          last_acc_cyc;
        int          stalls_left;
        bit          stall_started;
        bit          mid_done;
        bit          aborted;
        bit          finished;
        bit          full_ready;
        logic [31:0] live_bias;

        for (int i = 0; i < NW; i++) begin
            live_bias = m_bias >> ((i / PIX) * 16);
            m_exp[i]  = ref_word(m_in[i], live_bias[15:0]);
        end
        full_ready    = (k_piv == 100) && (k_por == 100) && !k_stall;
        in_idx        = 0;
        out_idx       = 0;
        done_cnt      = 0;
        done_cyc      = -1;
        last_in_cyc   = -1;
        last_acc_cyc  = -1;
        stalls_left   = 0;
        stall_started = 0;
        mid_done      = 0;
        aborted       = 0;
        finished      = 0;

        biases    = m_bias;
        start     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy after start"}, busy, 1);
        check({name, " out_valid after start"}, out_valid, 0);

        for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid = (in_idx < NW) && ($urandom_range(0, 99) < k_piv);
            in_data  = in_valid ? m_in[in_idx] : 16'($urandom);
            if (k_stall && out_valid && !stall_started) begin
                stall_started = 1;
                stalls_left   = 5;
            end
            if (stalls_left > 0) begin
                out_ready = 1'b0;
                stalls_left--;
            end else begin
                out_ready = ($urandom_range(0, 99) < k_por);
            end
            if (k_start_mid && (in_idx == 2) && !mid_done) begin
                start    = 1'b1;
                biases   = ~m_bias ^ $urandom();
                mid_done = 1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done_cnt > 0) begin
                check({name, " done one cycle"}, done, 0);
                check({name, " busy back to idle"}, busy, 0);
                check({name, " in_ready idle"}, in_ready, 0);
                finished = 1;
            end else begin
                if (out_valid && !out_ready) begin
                    check({name, " in_ready under stall"}, in_ready, 0);
                    if (out_idx < NW) check({name, " held data"}, out_data, m_exp[out_idx]);
                end
                if (out_valid && out_ready) begin
                    if (out_idx < NW) begin
                        check($sformatf("%s word%0d", name, out_idx), out_data, m_exp[out_idx]);
                        check($sformatf("%s last%0d", name, out_idx), out_last, (out_idx == NW - 1));
                    end else begin
                        check({name, " extra word"}, out_idx, NW - 1);
                    end
                    out_idx++;
                    if (out_idx == NW) last_acc_cyc = cyc;
                end
                if (in_valid && in_ready) begin
                    in_idx++;
                    if (in_idx == NW) last_in_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check({name, " out_valid at done"}, out_valid, 0);
                    check({name, " out_last at done"}, out_last, 0);
                end
            end
            if (finished) break;
            @(posedge clk); #1;
            if (k_abort && (in_idx == 3)) begin
                aborted = 1;
                break;
            end
        end

        start    = 1'b0;
        in_valid = 1'b0;
        biases   = m_bias;
        if (aborted) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check({name, " busy after abort"}, busy, 0);
            check({name, " out_valid after abort"}, out_valid, 0);
            check({name, " out_last after abort"}, out_last, 0);
            check({name, " out_data after abort"}, out_data, 0);
            check({name, " in_ready after abort"}, in_ready, 0);
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                check({name, " no done after abort"}, done, 0);
            end
        end else begin
            check({name, " words out"}, out_idx, NW);
            check({name, " words in"}, in_idx, NW);
            check({name, " done pulses"}, done_cnt, 1);
            check({name, " done after last accept"}, done_cyc, last_acc_cyc + 1);
            if (full_ready) check({name, " done latency"}, done_cyc - last_in_cyc, 2);
        end
        @(posedge clk); #1;
    endtask

    task automatic set_basic();
        m_bias = {16'h0010, 16'hFFF0};
        m_in   = '{16'h0020, 16'h0005, 16'h0100, 16'h8000,
                   16'h0001, 16'hFFFF, 16'h7000, 16'h0000};
    endtask

    task automatic set_random();
        m_bias = $urandom();
        for (int i = 0; i < NW; i++) m_in[i] = 16'($urandom);
    endtask

    task automatic set_knobs(input int piv, input int por, input bit stall,
                             input bit smid, input bit abrt);
        k_piv       = piv;
        k_por       = por;
        k_stall     = stall;
        k_start_mid = smid;
        k_abort     = abrt;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        biases    = '1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_last", out_last, 0);
        check("reset in_ready", in_ready, 0);
        check("reset out_data", out_data, 0);
        rst = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("idle without start busy", busy, 0);
        check("idle without start in_ready", in_ready, 0);
        in_valid = 1'b0;

        set_basic();
        set_knobs(100, 100, 0, 0, 0);
        run_map("basic");

        set_basic();
        set_knobs(100, 100, 1, 0, 0);
        run_map("backpressure");

        set_random();
        m_bias[15:0] = 16'h0001;
        m_in[0]      = 16'h7FFF;
        set_knobs(100, 100, 0, 0, 0);
        run_map("overflow");

        set_random();
        set_knobs(80, 80, 0, 1, 0);
        run_map("start_mid");

        set_random();
        set_knobs(100, 100, 0, 0, 1);
        run_map("abort");

        set_basic();
        set_knobs(100, 100, 0, 0, 0);
        run_map("after_abort");

        for (int r = 0; r < 6; r++) begin
            set_random();
            set_knobs(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0, 0, 0);
            run_map($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
